// File: rtl/dcache_unit.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines x 4 bytes,
// byte-wide CPU port, block-wide memory port.
module dcache_unit (
    input  logic        CLK,
    input  logic        RESET,
    output logic        busywait,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    input  logic [7:0]  address,
    input  logic        mem_busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    output logic [5:0]  mem_address
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] FETCH     = 2'd2;
    localparam logic [1:0] UPDATE    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [7:0]       valid_q, valid_d;
    logic [7:0]       dirty_q, dirty_d;
    logic [7:0][2:0]  tag_q, tag_d;
    logic [7:0][31:0] data_q, data_d;
    logic [31:0]      fetch_q, fetch_d;
    logic [7:0]       hold_q, hold_d;

    logic [2:0] addr_tag;
    logic [2:0] idx;
    logic [1:0] offset;
    logic       req;
    logic       hit;
    logic [7:0] cur_byte;

    assign addr_tag = address[7:5];
    assign idx      = address[4:2];
    assign offset   = address[1:0];
    assign req      = read || write;
    assign hit      = valid_q[idx] && (tag_q[idx] == addr_tag);
    assign cur_byte = data_q[idx][{offset, 3'b000} +: 8];

    always_comb begin
        busywait      = (state_q != IDLE) || (req && !hit);
        mem_read      = (state_q == FETCH);
        mem_write     = (state_q == WRITEBACK);
        mem_address   = (state_q == WRITEBACK) ? {tag_q[idx], idx} : {addr_tag, idx};
        mem_writedata = data_q[idx];
        // Load data is live while read is high; otherwise the last loaded byte is held.
        readdata      = read ? cur_byte : hold_q;
        hold_d        = read ? cur_byte : hold_q;
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        fetch_d = fetch_q;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FETCH;
                end else if (write) begin
                    data_d[idx][{offset, 3'b000} +: 8] = writedata;
                    dirty_d[idx] = 1'b1;
                end
            end
            WRITEBACK: begin
                if (!mem_busywait) state_d = FETCH;
            end
            FETCH: begin
                if (!mem_busywait) begin
                    fetch_d = mem_readdata;
                    state_d = UPDATE;
                end
            end
            default: begin
                data_d[idx]  = fetch_q;
                tag_d[idx]   = addr_tag;
                valid_d[idx] = 1'b1;
                dirty_d[idx] = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            hold_q  <= hold_d;
        end
    end

    // Tag and data contents are meaningless while invalid, so they carry no reset.
    always_ff @(posedge CLK) begin
        tag_q   <= tag_d;
        data_q  <= data_d;
        fetch_q <= fetch_d;
    end

endmodule

// File: tb/tb_dcache_unit.sv
// Directed bench for dcache_unit with a fixed-latency block memory model.
module tb_dcache_unit;

    localparam int MEM_LAT = 3;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        busywait;
    logic        read;
    logic        write;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic [7:0]  address;
    logic        mem_busywait;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic [5:0]  mem_address;

    dcache_unit dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .busywait      (busywait),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .address       (address),
        .mem_busywait  (mem_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_address   (mem_address)
    );

    always #5 CLK = ~CLK;

    // Memory: busy for MEM_LAT-1 cycles of each request, completes on the MEM_LAT-th.
    logic [31:0] mem [64];
    int          mcnt;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;

    always @(posedge CLK) begin
        if (load_en) mem[load_addr] <= load_data;
        if (RESET) begin
            mcnt <= 0;
        end else if (mem_read || mem_write) begin
            if (mcnt == MEM_LAT - 1) begin
                mcnt <= 0;
                if (mem_write) mem[mem_address] <= mem_writedata;
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    assign mem_busywait = (mem_read || mem_write) && (mcnt != MEM_LAT - 1);
    assign mem_readdata = mem[mem_address];

    int tests  = 0;
    int failed = 0;

    int          wb_cnt, rd_cnt, both_cnt;
    logic [5:0]  wb_addr, fetch_addr;
    logic [31:0] wb_data;
    int          stall;
    logic [7:0]  rd_val;

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wd;
        logic [7:0] exp_rd;
        int         exp_stall;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [5:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(posedge CLK); #1;
        load_en   = 1'b0;
    endtask

    // Called at posedge+1; holds the request until busywait drops, then one more edge.
    // stall excludes the initial IDLE miss cycle (refill-state cycles only).
    task automatic access(input logic r, input logic w, input logic [7:0] a, input logic [7:0] wd);
        int  bw;
        bit  done;
        bw = 0;
        done = 0;
        wb_cnt = 0;
        rd_cnt = 0;
        read = r;
        write = w;
        address = a;
        writedata = wd;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (mem_read && mem_write) both_cnt++;
            if (mem_write) begin
                wb_cnt++;
                wb_addr = mem_address;
                wb_data = mem_writedata;
            end
            if (mem_read) begin
                rd_cnt++;
                fetch_addr = mem_address;
            end
            if (!busywait) begin
                done = 1;
                break;
            end
            bw++;
            @(posedge CLK); #1;
        end
        if (!done) begin
            tests++;
            failed++;
            $display("FAIL access_timeout: busywait still 1 after 100 cycles, expected 0");
        end
        stall = (bw == 0) ? 0 : bw - 1;
        rd_val = readdata;
        @(posedge CLK); #1;
        read = 1'b0;
        write = 1'b0;
    endtask

    task automatic pulse_reset();
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        read = 1'b0;
        write = 1'b0;
        writedata = '0;
        address = '0;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
        both_cnt = 0;
        wb_addr = '0;
        wb_data = '0;
        fetch_addr = '0;

        vecs[0] = '{rd: 1'b1, wr: 1'b0, addr: 8'h03, wd: 8'h00, exp_rd: 8'h44, exp_stall: 0};
        vecs[1] = '{rd: 1'b1, wr: 1'b0, addr: 8'h00, wd: 8'h00, exp_rd: 8'h11, exp_stall: 0};
        vecs[2] = '{rd: 1'b0, wr: 1'b1, addr: 8'h01, wd: 8'hAB, exp_rd: 8'h00, exp_stall: 0};
        vecs[3] = '{rd: 1'b1, wr: 1'b0, addr: 8'h01, wd: 8'h00, exp_rd: 8'hAB, exp_stall: 0};
        vecs[4] = '{rd: 1'b1, wr: 1'b0, addr: 8'h02, wd: 8'h00, exp_rd: 8'h33, exp_stall: 0};

        @(posedge CLK); #1;
        load(6'h00, 32'h44332211);
        load(6'h08, 32'hDDCCBBAA);
        load(6'h39, 32'h0F0E0D0C);
        load(6'h01, 32'h04030201);
        load(6'h10, 32'h13121110);
        RESET = 1'b0;
        @(negedge CLK);
        chk("reset_busywait", busywait, 0);
        chk("reset_mem_read", mem_read, 0);
        chk("reset_mem_write", mem_write, 0);
        @(posedge CLK); #1;

        // Load line 0, then reset must invalidate it.
        access(1, 0, 8'h00, 8'h00);
        chk("first_read_data", rd_val, 8'h11);
        pulse_reset();
        access(1, 0, 8'h02, 8'h00);
        chk("clean_miss_stall", stall, MEM_LAT + 1);
        chk("clean_miss_fetch_cycles", rd_cnt, MEM_LAT);
        chk("clean_miss_fetch_addr", fetch_addr, 6'h00);
        chk("clean_miss_no_wb", wb_cnt, 0);
        chk("clean_miss_data", rd_val, 8'h33);

        foreach (vecs[i]) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd);
            chk($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
            if (vecs[i].rd) chk($sformatf("vec%0d_readdata", i), rd_val, vecs[i].exp_rd);
        end

        address = 8'h01;
        #1;
        chk("readdata_hold", readdata, 8'h33);
        @(posedge CLK); #1;
        chk("readdata_hold_after_edge", readdata, 8'h33);

        access(1, 0, 8'h20, 8'h00);
        chk("evict_stall", stall, 2 * MEM_LAT + 1);
        chk("evict_wb_cycles", wb_cnt, MEM_LAT);
        chk("evict_wb_addr", wb_addr, 6'h00);
        chk("evict_wb_data", wb_data, 32'h4433AB11);
        chk("evict_fetch_addr", fetch_addr, 6'h08);
        chk("evict_data", rd_val, 8'hAA);

        access(1, 0, 8'h01, 8'h00);
        chk("refetch_stall", stall, MEM_LAT + 1);
        chk("refetch_no_wb", wb_cnt, 0);
        chk("refetch_written_back_byte", rd_val, 8'hAB);
        access(1, 0, 8'h03, 8'h00);
        chk("hit_after_update_stall", stall, 0);
        chk("hit_after_update_data", rd_val, 8'h44);

        pulse_reset();
        access(0, 1, 8'hE7, 8'h5C);
        chk("wmiss_stall", stall, MEM_LAT + 1);
        chk("wmiss_fetch_addr", fetch_addr, 6'h39);
        chk("wmiss_no_wb", wb_cnt, 0);
        access(1, 0, 8'hE7, 8'h00);
        chk("wmiss_read_stall", stall, 0);
        chk("wmiss_read_data", rd_val, 8'h5C);
        access(1, 0, 8'hE4, 8'h00);
        chk("wmiss_other_byte", rd_val, 8'h0C);
        access(1, 0, 8'h07, 8'h00);
        chk("wmiss_dirty_stall", stall, 2 * MEM_LAT + 1);
        chk("wmiss_dirty_wb_addr", wb_addr, 6'h39);
        chk("wmiss_dirty_wb_data", wb_data, 32'h5C0E0D0C);
        chk("wmiss_dirty_data", rd_val, 8'h04);

        // Dirty line 1, then abort a refill of line 0 with reset.
        access(0, 1, 8'h06, 8'h99);
        chk("dirtying_write_stall", stall, 0);
        read = 1'b1;
        address = 8'h40;
        @(negedge CLK);
        chk("midrst_miss_busywait", busywait, 1);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("midrst_in_fetch", mem_read, 1);
        chk("midrst_fetch_addr", mem_address, 6'h10);
        RESET = 1'b1;
        read = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("midrst_mem_read", mem_read, 0);
        chk("midrst_mem_write", mem_write, 0);
        chk("midrst_busywait", busywait, 0);
        @(posedge CLK); #1;
        access(1, 0, 8'h06, 8'h00);
        chk("midrst_invalid_stall", stall, MEM_LAT + 1);
        chk("midrst_dirty_cleared", wb_cnt, 0);
        chk("midrst_refetch_data", rd_val, 8'h03);

        chk("no_simultaneous_mem_rw", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
